// File: rtl/udp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// udp_pkg: shared TX/RX arbitration types and round-robin helper
// Rev 1.0
// ------------------------------------------------------------------
package udp_pkg;

  localparam int IP_W    = 32;
  localparam int PORT_W  = 16;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SEND     = 3'd2,
    START    = 3'd3,
    DONE     = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scanning from the farthest candidate back to the nearest lets the
  // nearest eligible index after last_grant overwrite all others.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] eligible,
                                       input logic [IDX_W-1:0]   last_grant,
                                       input int                 num_req);
    rr_pick_t         r;
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    r = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        cand     = (int'(last_grant) + k) % num_req;
        cand_idx = IDX_W'(cand);
        if (eligible[cand_idx]) begin
          r.valid = 1'b1;
          r.idx   = cand_idx;
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arbiter: pure round-robin picker, shared by TX and RX dispatch
// Rev 1.0
// ------------------------------------------------------------------
module rr_arbiter
  import udp_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [MAX_REQ-1:0] w_eligible_ext;
  rr_pick_t           w_pick;

  assign w_eligible_ext = MAX_REQ'(eligible);
  assign w_pick         = rr_pick(w_eligible_ext, last_grant, NUM_REQ);
  assign grant_valid    = w_pick.valid;
  assign grant_idx      = w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// udp_tx_arbiter: round-robin sharing of the udp core TX path
// Rev 1.0
// ------------------------------------------------------------------
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int          NUM_REQ       = 2,
  parameter int          PAYLOAD_BYTES = 10,
  parameter logic [31:0] TIMEOUT       = 32'd5000000
) (
  input  logic                               clk50m,
  input  logic                               ready,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [IP_W*NUM_REQ-1:0]            req_ip,
  input  logic [PORT_W*NUM_REQ-1:0]          req_port,
  input  logic [8*PAYLOAD_BYTES*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_done,
  output logic [NUM_REQ-1:0]                 req_err,
  output logic                               busy,
  output logic [IP_W-1:0]                    tx_ip_o,
  output logic [PORT_W-1:0]                  tx_dst_port_o,
  output logic                               tx_req_o,
  output logic [7:0]                         tx_data_o,
  output logic                               tx_data_av_o,
  input  logic                               tx_req_rdy_i,
  input  logic                               tx_data_rdy_i
);

  localparam int         PL_W      = 8 * PAYLOAD_BYTES;
  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  tx_state_e          r_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant;
  logic [PL_W-1:0]    r_shift;
  logic [7:0]         r_byte_cnt;
  logic [31:0]        r_wait;

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_grant_valid;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IP_W-1:0]    w_ip_sel;
  logic [PORT_W-1:0]  w_port_sel;
  logic [PL_W-1:0]    w_data_sel;
  logic [NUM_REQ-1:0] w_grant_onehot;
  logic [PL_W-1:0]    w_shift_next;

  // Masking the pulse outputs keeps a just-acknowledged requester from
  // winning again before it has had a chance to drop valid.
  assign w_eligible   = req_valid & ~req_done & ~req_err;
  assign w_shift_next = r_shift << 8;
  assign busy         = (r_state != IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .eligible    (w_eligible),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_ip_sel       = '0;
    w_port_sel     = '0;
    w_data_sel     = '0;
    w_grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_ip_sel   = req_ip[i*IP_W +: IP_W];
        w_port_sel = req_port[i*PORT_W +: PORT_W];
        w_data_sel = req_data[i*PL_W +: PL_W];
      end
      w_grant_onehot[i] = (r_grant == IDX_W'(i));
    end
  end

  always_ff @(posedge clk50m or negedge ready) begin
    if (!ready) begin
      r_state       <= IDLE;
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
      r_grant       <= '0;
      r_shift       <= '0;
      r_byte_cnt    <= '0;
      r_wait        <= '0;
      req_done      <= '0;
      req_err       <= '0;
      tx_ip_o       <= '0;
      tx_dst_port_o <= '0;
      tx_req_o      <= 1'b0;
      tx_data_o     <= '0;
      tx_data_av_o  <= 1'b0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            tx_ip_o       <= w_ip_sel;
            tx_dst_port_o <= w_port_sel;
            r_shift       <= w_data_sel;
            r_grant       <= w_grant_idx;
            r_byte_cnt    <= '0;
            r_wait        <= '0;
            r_state       <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (tx_req_rdy_i) begin
            tx_data_o    <= r_shift[PL_W-1 -: 8];
            tx_data_av_o <= 1'b1;
            r_state      <= SEND;
          end else if (r_wait == TIMEOUT - 32'd1) begin
            tx_data_av_o <= 1'b0;
            tx_req_o     <= 1'b0;
            req_err      <= w_grant_onehot;
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        SEND: begin
          if (tx_data_av_o && tx_data_rdy_i) begin
            r_shift    <= w_shift_next;
            r_byte_cnt <= r_byte_cnt + 8'd1;
            if (r_byte_cnt == LAST_BYTE) begin
              tx_data_av_o <= 1'b0;
              r_wait       <= '0;
              r_state      <= START;
            end else begin
              tx_data_o <= w_shift_next[PL_W-1 -: 8];
            end
          end
        end
        START: begin
          if (tx_req_rdy_i) begin
            tx_req_o <= 1'b1;
            r_state  <= DONE;
          end else if (r_wait == TIMEOUT - 32'd1) begin
            tx_data_av_o <= 1'b0;
            tx_req_o     <= 1'b0;
            req_err      <= w_grant_onehot;
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        DONE: begin
          tx_req_o     <= 1'b0;
          req_done     <= w_grant_onehot;
          r_last_grant <= r_grant;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_udp_tx_arbiter: directed vectors for the round-robin TX arbiter
// Rev 1.0
// ------------------------------------------------------------------
module tb_udp_tx_arbiter;

  localparam logic [31:0] IP0   = 32'hC0A80A01;
  localparam logic [31:0] IP1   = 32'hC0A80A02;
  localparam logic [15:0] PORT0 = 16'd2390;
  localparam logic [15:0] PORT1 = 16'd2391;
  localparam logic [79:0] DATA0 = 80'h0102030405060708090A;
  localparam logic [79:0] DATA1 = 80'h1112131415161718191A;
  localparam int          NB    = 10;
  localparam int          TMO   = 100;

  logic         clk50m = 1'b0;
  logic         ready;
  logic [1:0]   req_valid;
  logic [63:0]  req_ip;
  logic [31:0]  req_port;
  logic [159:0] req_data;
  logic [1:0]   req_done;
  logic [1:0]   req_err;
  logic         busy;
  logic [31:0]  tx_ip_o;
  logic [15:0]  tx_dst_port_o;
  logic         tx_req_o;
  logic [7:0]   tx_data_o;
  logic         tx_data_av_o;
  logic         tx_req_rdy_i;
  logic         tx_data_rdy_i = 1'b1;

  udp_tx_arbiter #(
    .NUM_REQ       (2),
    .PAYLOAD_BYTES (NB),
    .TIMEOUT       (32'(TMO))
  ) dut (
    .clk50m        (clk50m),
    .ready         (ready),
    .req_valid     (req_valid),
    .req_ip        (req_ip),
    .req_port      (req_port),
    .req_data      (req_data),
    .req_done      (req_done),
    .req_err       (req_err),
    .busy          (busy),
    .tx_ip_o       (tx_ip_o),
    .tx_dst_port_o (tx_dst_port_o),
    .tx_req_o      (tx_req_o),
    .tx_data_o     (tx_data_o),
    .tx_data_av_o  (tx_data_av_o),
    .tx_req_rdy_i  (tx_req_rdy_i),
    .tx_data_rdy_i (tx_data_rdy_i)
  );

  always #10 clk50m = ~clk50m;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         bp_mode = 1'b0;
  logic [7:0] q_bytes[$];
  int         req_pulses = 0, stab_err = 0, ovl_err = 0;
  int         done_cnt = 0, err_cnt = 0, last_done_idx = -1, last_err_idx = -1;
  logic [31:0] done_ip = '0;
  logic [15:0] done_port = '0;
  int         q_base = 0, pulse_base = 0;

  // Data-ready pattern 1,0,0 repeating under backpressure; changes 1 ns after each edge.
  initial begin
    int bp_cnt;
    bp_cnt = 0;
    forever begin
      @(posedge clk50m);
      #1;
      tx_data_rdy_i = bp_mode ? (bp_cnt % 3 == 0) : 1'b1;
      bp_cnt++;
    end
  end

  // Observer on the falling edge: values seen here are those the next rising edge acts on.
  initial begin
    logic       prev_av, prev_rdy;
    logic [7:0] prev_data;
    prev_av = 1'b0; prev_rdy = 1'b1; prev_data = '0;
    forever begin
      @(negedge clk50m);
      if (ready) begin
        if (prev_av && !prev_rdy && (tx_data_av_o !== 1'b1 || tx_data_o !== prev_data))
          stab_err++;
        if (tx_data_av_o && tx_data_rdy_i) q_bytes.push_back(tx_data_o);
        if (tx_req_o && tx_data_av_o) ovl_err++;
        if (tx_req_o) req_pulses++;
        if (req_done != 2'b00) begin
          done_cnt++;
          last_done_idx = (req_done == 2'b01) ? 0 : (req_done == 2'b10) ? 1 : 9;
          done_ip   = tx_ip_o;
          done_port = tx_dst_port_o;
        end
        if (req_err != 2'b00) begin
          err_cnt++;
          last_err_idx = (req_err == 2'b01) ? 0 : (req_err == 2'b10) ? 1 : 9;
        end
      end
      prev_av = tx_data_av_o; prev_rdy = tx_data_rdy_i; prev_data = tx_data_o;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int idx, input int k);
    return 8'(idx * 16 + k + 1);
  endfunction

  task automatic wait_bytes(input string name, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (q_bytes.size() - q_base >= n) begin ok = 1'b1; break; end
    end
    check({name, "_bytes_reached"}, 64'(ok), 64'd1);
  endtask

  // Waits for the next done pulse, compares the finished packet, then
  // drops the winner's valid for one cycle (restoring it when rearm=1).
  task automatic check_packet(input string name, input int exp_idx, input bit rearm);
    bit ok;
    int start, nb, bad;
    ok = 1'b0;
    start = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_cnt != start) begin ok = 1'b1; break; end
    end
    check({name, "_done_seen"}, 64'(ok), 64'd1);
    check({name, "_grant_idx"}, 64'(last_done_idx), 64'(exp_idx));
    check({name, "_ip"}, 64'(done_ip), 64'(exp_idx == 1 ? IP1 : IP0));
    check({name, "_port"}, 64'(done_port), 64'(exp_idx == 1 ? PORT1 : PORT0));
    nb = q_bytes.size() - q_base;
    check({name, "_accepts"}, 64'(nb), 64'(NB));
    bad = 0;
    for (int k = 0; k < nb && k < NB; k++)
      if (q_bytes[q_base + k] !== exp_byte(exp_idx, k)) bad++;
    check({name, "_byte_errs"}, 64'(bad), 64'd0);
    check({name, "_req_pulses"}, 64'(req_pulses - pulse_base), 64'd1);
    check({name, "_stall_stable_errs"}, 64'(stab_err), 64'd0);
    q_base     = q_bytes.size();
    pulse_base = req_pulses;
    req_valid[exp_idx] = 1'b0;
    tick();
    if (rearm) req_valid[exp_idx] = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [1:0] set_mask;
    bit         bp;
    int         exp_idx;
    bit         rearm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit ok;
    int n, eb;

    // Requester 0 wins first after reset; once it has been served,
    // contention alternates starting from requester 1.
    vecs[0] = '{"single",    2'b01, 1'b0, 0, 1'b0};
    vecs[1] = '{"cont_a",    2'b11, 1'b0, 1, 1'b1};
    vecs[2] = '{"cont_b",    2'b00, 1'b0, 0, 1'b1};
    vecs[3] = '{"cont_c",    2'b00, 1'b0, 1, 1'b0};
    vecs[4] = '{"cont_d",    2'b00, 1'b0, 0, 1'b0};
    vecs[5] = '{"bp_r0",     2'b01, 1'b1, 0, 1'b0};
    vecs[6] = '{"bp_r1",     2'b10, 1'b1, 1, 1'b0};

    ready        = 1'b0;
    req_valid    = 2'b00;
    req_ip       = {IP1, IP0};
    req_port     = {PORT1, PORT0};
    req_data     = {DATA1, DATA0};
    tx_req_rdy_i = 1'b1;
    repeat (3) tick();
    check("reset_ctrl", 64'({busy, tx_req_o, tx_data_av_o, req_done, req_err}), 64'd0);
    check("reset_bus", 64'({tx_ip_o, tx_dst_port_o, tx_data_o}), 64'd0);
    ready = 1'b1;
    tick();
    check("reset_idle_after_release", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++) begin
      bp_mode   = vecs[i].bp;
      req_valid = req_valid | vecs[i].set_mask;
      check_packet(vecs[i].name, vecs[i].exp_idx, vecs[i].rearm);
    end
    bp_mode = 1'b0;
    check("after_vectors_idle", 64'(busy), 64'd0);

    // Timeout: requester 0 is granted (last grant was 1), request-ready never comes.
    tx_req_rdy_i = 1'b0;
    req_valid    = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) begin ok = 1'b1; break; end
    end
    check("to_busy", 64'(ok), 64'd1);
    eb = err_cnt;
    n  = 0;
    while (err_cnt == eb && n < 300) begin tick(); n++; end
    check("to_err_seen", 64'(err_cnt - eb), 64'd1);
    // TMO full waiting cycles after the grant edge, then the pulse cycle.
    check("to_cycles", 64'(n), 64'(TMO + 1));
    check("to_err_idx", 64'(last_err_idx), 64'd0);
    check("to_no_req", 64'(req_pulses - pulse_base), 64'd0);
    check("to_no_bytes", 64'(q_bytes.size() - q_base), 64'd0);
    req_valid[0] = 1'b0;
    tx_req_rdy_i = 1'b1;
    check_packet("to_next", 1, 1'b0);

    // Asynchronous reset in the middle of a payload.
    req_valid = 2'b01;
    wait_bytes("rst", 4);
    #3;
    ready = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({busy, tx_req_o, tx_data_av_o, req_done, req_err}), 64'd0);
    check("rst_mid_bus", 64'({tx_ip_o, tx_dst_port_o, tx_data_o}), 64'd0);
    tick();
    tick();
    q_base     = q_bytes.size();
    pulse_base = req_pulses;
    req_valid  = 2'b11;
    tick();
    ready = 1'b1;
    check_packet("rst_r0", 0, 1'b0);
    check_packet("rst_r1", 1, 1'b0);

    // Payload changes after the latch must not reach the wire.
    req_valid = 2'b01;
    wait_bytes("late", 3);
    req_data[79:0] = 80'hF0E0D0C0B0A090807060;
    check_packet("late", 0, 1'b0);
    req_data[79:0] = DATA0;

    check("no_req_av_overlap", 64'(ovl_err), 64'd0);
    tick();
    check("final_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
